// File: rtl/noc_pckt_tx.sv
// noc_pckt_tx: resource-side packet transmitter feeding one xy_switch input.
// Buffers core requests in a small FIFO and writes them into the switch FIFO.
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   req_valid_i/ready_o    local request handshake
//   req_col_i/row_i/data_i request fields
//   wr_en_sw_o, pckt_sw_o  write strobe and packet to the switch
//   nxt_fifo_full_i        switch FIFO full (gates wr_en_sw_o)
//   nxt_fifo_overflow_i    switch overflow -> sticky error state
//   tx_err_o, tx_cnt_o     sticky error, wrapping sent-packet count
//   tx_fifo_empty_o        local FIFO empty
module noc_pckt_tx #(
  parameter int PCKT_COL_ADDR_W = 4,
  parameter int PCKT_ROW_ADDR_W = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_COL_ADDR_W
                                + PCKT_ROW_ADDR_W
                                + PCKT_DATA_W,
  parameter int TX_FIFO_DEPTH_W = 2,
  parameter int TX_CNT_W        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [PCKT_COL_ADDR_W-1:0] req_col_i,
  input  logic [PCKT_ROW_ADDR_W-1:0] req_row_i,
  input  logic [PCKT_DATA_W-1:0]     req_data_i,
  output logic                       wr_en_sw_o,
  output logic [PCKT_W-1:0]          pckt_sw_o,
  input  logic                       nxt_fifo_full_i,
  input  logic                       nxt_fifo_overflow_i,
  output logic                       tx_err_o,
  output logic [TX_CNT_W-1:0]        tx_cnt_o,
  output logic                       tx_fifo_empty_o
);

  localparam int DEPTH = 1 << TX_FIFO_DEPTH_W;
  localparam int CW    = TX_FIFO_DEPTH_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {RUN, ERR} state_t;

  state_t                     state;
  logic [PCKT_W-1:0]          mem [DEPTH];
  logic [TX_FIFO_DEPTH_W-1:0] wr_ptr;
  logic [TX_FIFO_DEPTH_W-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic                       empty;
  logic                       push;
  logic                       pop;

  assign empty           = (count == '0);
  assign tx_fifo_empty_o = empty;

  // Ready uses only registered state: no bypass when full.
  assign req_ready_o = (count != FULL_CNT) && (state == RUN);
  assign push        = req_valid_i && req_ready_o;

  // Combinational on full so the switch FIFO is never written while full.
  assign wr_en_sw_o = !empty && !nxt_fifo_full_i && (state == RUN);
  assign pop        = wr_en_sw_o;

  assign pckt_sw_o = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {req_col_i, req_row_i, req_data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= RUN;
      tx_err_o <= 1'b0;
      tx_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_cnt_o <= tx_cnt_o + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A write coinciding with overflow still completes above.
      unique case (state)
        RUN: begin
          if (nxt_fifo_overflow_i) begin
            state    <= ERR;
            tx_err_o <= 1'b1;
          end
        end
        ERR: begin
          state    <= ERR;
          tx_err_o <= 1'b1;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_pckt_tx.sv
// tb_noc_pckt_tx: directed self-checking bench for noc_pckt_tx.
// A second instance with a 4-bit counter shares stimulus for the wrap test.
module tb_noc_pckt_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  col = '0;
  logic [3:0]  row = '0;
  logic [7:0]  data = '0;
  logic        full = 1'b0;
  logic        ovf = 1'b0;

  logic        ready, wr_en, err, empty;
  logic [15:0] pckt;
  logic [15:0] cnt;
  logic        ready4, wr_en4, err4, empty4;
  logic [15:0] pckt4;
  logic [3:0]  cnt4;

  int checks = 0;
  int failures = 0;
  int sent, rcv;

  always #5 clk = ~clk;

  noc_pckt_tx dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_col_i(col), .req_row_i(row), .req_data_i(data),
    .wr_en_sw_o(wr_en), .pckt_sw_o(pckt),
    .nxt_fifo_full_i(full), .nxt_fifo_overflow_i(ovf),
    .tx_err_o(err), .tx_cnt_o(cnt), .tx_fifo_empty_o(empty)
  );

  noc_pckt_tx #(.TX_CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_ready_o(ready4),
    .req_col_i(col), .req_row_i(row), .req_data_i(data),
    .wr_en_sw_o(wr_en4), .pckt_sw_o(pckt4),
    .nxt_fifo_full_i(full), .nxt_fifo_overflow_i(ovf),
    .tx_err_o(err4), .tx_cnt_o(cnt4), .tx_fifo_empty_o(empty4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    full  = 1'b0;
    ovf   = 1'b0;
    rst   = 1'b1;
    step();
    step();
    rst   = 1'b0;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_cnt"},   32'(cnt),   32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
    chk({tag, "_pckt"},  32'(pckt),  32'd0);
  endtask

  initial begin
    // Reset then idle
    do_reset();
    step();
    chk_reset("rst_idle");

    // Single packet 2/3/A5
    col = 4'd2; row = 4'd3; data = 8'hA5; valid = 1'b1;
    #1;
    chk("single_ready", 32'(ready), 32'd1);
    step();
    valid = 1'b0;
    #1;
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_pckt",  32'(pckt),  32'h23A5);
    step();
    chk("single_wr_en_off", 32'(wr_en), 32'd0);
    chk("single_cnt",       32'(cnt),   32'd1);
    chk("single_empty",     32'(empty), 32'd1);

    // Backpressure: 5 offered, 4 accepted
    do_reset();
    full = 1'b1; col = 4'd1; row = 4'd0;
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; data = 8'(i);
      #1;
      chk("bp_wr_en_low", 32'(wr_en), 32'd0);
      if (ready) sent++;
      step();
    end
    valid = 1'b0;
    #1;
    chk("bp_accepted", 32'(sent),  32'd4);
    chk("bp_ready",    32'(ready), 32'd0);
    chk("bp_head",     32'(pckt),  32'h1000);
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_wr_en",  32'(wr_en), 32'd1);
      chk("bp_pckt",   32'(pckt),  32'h1000 + 32'(i));
      step();
    end
    chk("bp_done_wr_en", 32'(wr_en), 32'd0);
    chk("bp_cnt",        32'(cnt),   32'd4);

    // Full-flag toggles every cycle while streaming 6 packets
    do_reset();
    sent = 0; rcv = 0;
    col = 4'd5; row = 4'd6;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      full  = c[0];
      valid = (sent < 6);
      data  = 8'(sent);
      #1;
      chk("tog_no_wr_full", 32'(wr_en && full), 32'd0);
      if (wr_en) begin
        chk("tog_pckt", 32'(pckt), 32'h5600 + 32'(rcv));
        rcv++;
      end
      if (valid && ready) sent++;
      step();
    end
    valid = 1'b0; full = 1'b0;
    #1;
    chk("tog_rcv",   32'(rcv),   32'd6);
    chk("tog_cnt",   32'(cnt),   32'd6);
    chk("tog_empty", 32'(empty), 32'd1);

    // Overflow with 2 packets still queued
    do_reset();
    full = 1'b1; col = 4'd7; row = 4'd8;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = 8'(i);
      step();
    end
    valid = 1'b0; full = 1'b0;
    step();
    step();
    chk("ovf_pre_cnt", 32'(cnt), 32'd2);
    full = 1'b1; ovf = 1'b1;
    step();
    ovf = 1'b0; full = 1'b0; valid = 1'b1; data = 8'h55;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_err",   32'(err),   32'd1);
      chk("ovf_wr_en", 32'(wr_en), 32'd0);
      chk("ovf_ready", 32'(ready), 32'd0);
      chk("ovf_cnt",   32'(cnt),   32'd2);
      chk("ovf_head",  32'(pckt),  32'h7802);
      step();
    end
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("ovf_rst");
    rst = 1'b0;
    step();
    chk_reset("ovf_rst_rel");

    // Overflow coinciding with a write: write completes
    do_reset();
    full = 1'b1; col = 4'd1; row = 4'd2;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; data = 8'(8'hB0 + i);
      step();
    end
    valid = 1'b0; full = 1'b0; ovf = 1'b1;
    #1;
    chk("coin_wr_en", 32'(wr_en), 32'd1);
    step();
    ovf = 1'b0;
    #1;
    chk("coin_cnt",   32'(cnt),   32'd1);
    chk("coin_err",   32'(err),   32'd1);
    chk("coin_wr_en_off", 32'(wr_en), 32'd0);
    chk("coin_head",  32'(pckt),  32'h12B1);

    // Counter wrap on the 4-bit instance
    do_reset();
    col = 4'd0; row = 4'd0;
    for (int k = 1; k <= 17; k++) begin
      valid = 1'b1; data = 8'(k);
      step();
      valid = 1'b0;
      step();
      chk("wrap_cnt16", 32'(cnt),  32'(k));
      chk("wrap_cnt4",  32'(cnt4), 32'(k % 16));
    end
    chk("wrap_err4", 32'(err4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
